recovery_controller: RTL and testbench

Sequences precise-exception recovery around the history file. It arbitrates the integer register-file write port between normal writeback and history-file rollback writes. It holds the front end stalled and flushed during rollback, commits the trap CSRs (mepc/mcause/mtval), then issues a single-cycle PC redirect to the trap vector. It sits between the history file, the writeback stage, the CSR file and fetch.

---
 rtl/recovery_controller.sv | 141 ++++++++++++++
 tb/tb_recovery_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recovery_controller.sv
// Precise-exception recovery sequencer: arbitrates the RF write port,
// holds the front end during rollback, commits trap CSRs and redirects.
module recovery_controller #(
  parameter int              XLEN          = 32,
  parameter int              MAX_RESTORE   = 32,
  parameter logic [XLEN-1:0] CAUSE_TIMEOUT = 'h18
) (
  input  logic            clk_i,
  input  logic            rsn_i,
  input  logic            wb_write_en_i,
  input  logic [4:0]      wb_dest_reg_i,
  input  logic [XLEN-1:0] wb_value_i,
  input  logic            kill_instr_i,
  input  logic [XLEN-1:0] kill_pc_i,
  input  logic            rec_write_en_i,
  input  logic [4:0]      rec_dest_reg_i,
  input  logic [XLEN-1:0] rec_dest_reg_value_i,
  input  logic            exc_occured_i,
  input  logic [XLEN-1:0] exc_mepc_i,
  input  logic [XLEN-1:0] exc_mcause_i,
  input  logic [XLEN-1:0] exc_mtval_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_addr_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            wb_drop_o,
  output logic            csr_we_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            pc_redirect_valid_o,
  output logic [XLEN-1:0] pc_redirect_o,
  output logic [4:0]      restore_cnt_o,
  output logic            err_o
);

  localparam int TW = $clog2(MAX_RESTORE + 1);
  localparam logic [TW-1:0] TLAST = TW'(MAX_RESTORE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RESTORE,
    TRAP,
    REDIRECT
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [XLEN-1:0] kill_pc;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state               <= IDLE;
      timer               <= '0;
      kill_pc             <= '0;
      stall_o             <= 1'b0;
      flush_o             <= 1'b0;
      csr_we_o            <= 1'b0;
      pc_redirect_valid_o <= 1'b0;
      mepc_o              <= '0;
      mcause_o            <= '0;
      mtval_o             <= '0;
      restore_cnt_o       <= '0;
      err_o               <= 1'b0;
    end else begin
      csr_we_o            <= 1'b0;
      pc_redirect_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exc_occured_i || rec_write_en_i)
            err_o <= 1'b1;
          if (kill_instr_i) begin
            state         <= RESTORE;
            kill_pc       <= kill_pc_i;
            restore_cnt_o <= '0;
            timer         <= '0;
            stall_o       <= 1'b1;
            flush_o       <= 1'b1;
          end
        end
        RESTORE: begin
          timer <= timer + TW'(1);
          if (rec_write_en_i && restore_cnt_o != 5'd31)
            restore_cnt_o <= restore_cnt_o + 5'd1;
          if (exc_occured_i) begin
            mepc_o   <= exc_mepc_i;
            mcause_o <= exc_mcause_i;
            mtval_o  <= exc_mtval_i;
            csr_we_o <= 1'b1;
            state    <= TRAP;
          end else if (timer == TLAST) begin
            // History file never reported: trap on the kill PC instead
            err_o    <= 1'b1;
            mepc_o   <= kill_pc;
            mcause_o <= CAUSE_TIMEOUT;
            mtval_o  <= '0;
            csr_we_o <= 1'b1;
            state    <= TRAP;
          end
        end
        TRAP: begin
          state               <= REDIRECT;
          flush_o             <= 1'b0;
          pc_redirect_valid_o <= 1'b1;
        end
        REDIRECT: begin
          state   <= IDLE;
          stall_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rf_we_o   = 1'b0;
    rf_addr_o = wb_dest_reg_i;
    rf_data_o = wb_value_i;
    wb_drop_o = 1'b0;
    unique case (state)
      IDLE: begin
        rf_we_o = wb_write_en_i && (wb_dest_reg_i != 5'd0);
      end
      RESTORE: begin
        rf_we_o   = rec_write_en_i && (rec_dest_reg_i != 5'd0);
        rf_addr_o = rec_dest_reg_i;
        rf_data_o = rec_dest_reg_value_i;
        wb_drop_o = wb_write_en_i;
      end
      default: begin
        wb_drop_o = wb_write_en_i;
      end
    endcase
  end

  assign pc_redirect_o = pc_redirect_valid_o
    ? {mtvec_i[XLEN-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_recovery_controller.sv
// Bench for recovery_controller: vector table, corner
// sequences and a random run against a cycle-index model.
module tb_recovery_controller;

  localparam int MAXR = 32;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_val;
  logic        kill;
  logic [31:0] kpc;
  logic        rec_we;
  logic [4:0]  rec_dest;
  logic [31:0] rec_val;
  logic        exc;
  logic [31:0] e_mepc, e_mcause, e_mtval, mtvec;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall, flush, drop, csr_we;
  logic [31:0] mepc, mcause, mtval;
  logic        pcv;
  logic [31:0] pc;
  logic [4:0]  cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  recovery_controller #(
    .XLEN(32), .MAX_RESTORE(MAXR), .CAUSE_TIMEOUT(32'h18)
  ) dut (
    .clk_i(clk), .rsn_i(rsn),
    .wb_write_en_i(wb_we), .wb_dest_reg_i(wb_dest),
    .wb_value_i(wb_val),
    .kill_instr_i(kill), .kill_pc_i(kpc),
    .rec_write_en_i(rec_we), .rec_dest_reg_i(rec_dest),
    .rec_dest_reg_value_i(rec_val),
    .exc_occured_i(exc), .exc_mepc_i(e_mepc),
    .exc_mcause_i(e_mcause), .exc_mtval_i(e_mtval),
    .mtvec_i(mtvec),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .stall_o(stall), .flush_o(flush), .wb_drop_o(drop),
    .csr_we_o(csr_we), .mepc_o(mepc), .mcause_o(mcause),
    .mtval_o(mtval),
    .pc_redirect_valid_o(pcv), .pc_redirect_o(pc),
    .restore_cnt_o(cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic idle_in();
    wb_we = 0; wb_dest = 0; wb_val = 0;
    kill = 0; kpc = 0;
    rec_we = 0; rec_dest = 0; rec_val = 0;
    exc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rsn = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
  endtask

  typedef struct {
    logic kill; logic [31:0] kpc;
    logic rwe; logic [4:0] rd; logic [31:0] rv;
    logic exc;
    logic wwe; logic [4:0] wd; logic [31:0] wv;
    logic we; logic [4:0] addr; logic [31:0] data;
    logic st, fl, dr, csr, pcv;
    logic [31:0] pc;
    logic [4:0] cnt;
    logic err;
  } vec_t;

  vec_t tbl[12];

  // random-run model: phases as absolute cycle indices
  int          cyc, rest_start, trap_at, redir_at;
  bit          in_rest, m_err;
  logic [4:0]  m_cnt;
  logic [31:0] m_kpc, m_mepc, m_mcause, m_mtval;

  initial begin
    int n;
    bit seen;
    idle_in();
    e_mepc = 32'h100; e_mcause = 32'h2;
    e_mtval = 32'h0badc0de; mtvec = 32'h8000_0001;

    tbl[0]  = '{0,0, 0,0,0, 0, 1,5,32'hdeadbeef,
                1,5,32'hdeadbeef, 0,0,0,0,0, 0, 0, 0};
    tbl[1]  = '{0,0, 0,0,0, 0, 1,0,32'hdeadbeef,
                0,0,32'hdeadbeef, 0,0,0,0,0, 0, 0, 0};
    tbl[2]  = '{1,32'h100, 0,0,0, 0, 1,5,32'hdeadbeef,
                1,5,32'hdeadbeef, 0,0,0,0,0, 0, 0, 0};
    tbl[3]  = '{0,0, 1,3,1, 0, 1,5,32'hdeadbeef,
                1,3,1, 1,1,1,0,0, 0, 0, 0};
    tbl[4]  = '{1,32'h444, 1,4,2, 0, 1,5,32'hdeadbeef,
                1,4,2, 1,1,1,0,0, 0, 1, 0};
    tbl[5]  = '{0,0, 1,5,3, 1, 1,5,32'hdeadbeef,
                1,5,3, 1,1,1,0,0, 0, 2, 0};
    tbl[6]  = '{0,0, 0,0,0, 0, 1,5,32'hdeadbeef,
                0,0,0, 1,1,1,1,0, 0, 3, 0};
    tbl[7]  = '{1,32'h555, 0,0,0, 0, 1,5,32'hdeadbeef,
                0,0,0, 1,0,1,0,1, 32'h8000_0000, 3, 0};
    tbl[8]  = '{0,0, 0,0,0, 0, 1,5,32'hdeadbeef,
                1,5,32'hdeadbeef, 0,0,0,0,0, 0, 3, 0};
    tbl[9]  = '{0,0, 0,0,0, 1, 0,0,0,
                0,0,0, 0,0,0,0,0, 0, 3, 0};
    tbl[10] = '{0,0, 0,0,0, 0, 0,0,0,
                0,0,0, 0,0,0,0,0, 0, 3, 1};
    tbl[11] = '{0,0, 1,7,9, 0, 0,0,0,
                0,0,0, 0,0,0,0,0, 0, 3, 1};

    do_reset();
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_err", err, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      kill = tbl[i].kill; kpc = tbl[i].kpc;
      rec_we = tbl[i].rwe; rec_dest = tbl[i].rd;
      rec_val = tbl[i].rv; exc = tbl[i].exc;
      wb_we = tbl[i].wwe; wb_dest = tbl[i].wd;
      wb_val = tbl[i].wv;
      #1;
      chk($sformatf("v%0d_we", i), rf_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), rf_addr, tbl[i].addr);
        chk($sformatf("v%0d_data", i), rf_data, tbl[i].data);
      end
      chk($sformatf("v%0d_stall", i), stall, tbl[i].st);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].fl);
      chk($sformatf("v%0d_drop", i), drop, tbl[i].dr);
      chk($sformatf("v%0d_csr", i), csr_we, tbl[i].csr);
      chk($sformatf("v%0d_pcv", i), pcv, tbl[i].pcv);
      if (tbl[i].pcv)
        chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      if (tbl[i].csr) begin
        chk($sformatf("v%0d_mepc", i), mepc, 32'h100);
        chk($sformatf("v%0d_mcause", i), mcause, 32'h2);
        chk($sformatf("v%0d_mtval", i), mtval, 32'h0badc0de);
      end
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), err, tbl[i].err);
    end

    // timeout: RESTORE lasts exactly MAXR cycles
    do_reset();
    @(negedge clk);
    idle_in();
    kill = 1; kpc = 32'h200;
    #1;
    chk("to_err0", err, 0);
    n = 0;
    seen = 0;
    for (int k = 0; k < 3 * MAXR; k++) begin
      @(negedge clk);
      idle_in();
      #1;
      if (csr_we) begin
        seen = 1;
        break;
      end
      if (stall && flush) n++;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_len", n, MAXR);
    chk("to_mepc", mepc, 32'h200);
    chk("to_mcause", mcause, 32'h18);
    chk("to_mtval", mtval, 0);
    chk("to_err1", err, 1);
    @(negedge clk);
    #1;
    chk("to_pcv", pcv, 1);
    chk("to_pc", pc, 32'h8000_0000);
    @(negedge clk);
    #1;
    chk("to_idle", stall, 0);
    chk("to_pcv0", pcv, 0);

    // asynchronous reset in the middle of RESTORE
    do_reset();
    @(negedge clk);
    kill = 1; kpc = 32'h300;
    @(negedge clk);
    idle_in();
    rec_we = 1; rec_dest = 1; rec_val = 7;
    @(negedge clk);
    @(negedge clk);
    idle_in();
    #1;
    chk("ar_pre_cnt", cnt, 2);
    chk("ar_pre_stall", stall, 1);
    #1;
    rsn = 1'b0;
    #1;
    chk("ar_stall", stall, 0);
    chk("ar_flush", flush, 0);
    chk("ar_cnt", cnt, 0);
    chk("ar_csr", csr_we, 0);
    chk("ar_pcv", pcv, 0);
    chk("ar_err", err, 0);
    @(negedge clk);
    rsn = 1'b1;
    wb_we = 1; wb_dest = 9; wb_val = 32'h1234;
    #1;
    chk("ar_idle_we", rf_we, 1);
    chk("ar_idle_drop", drop, 0);
    @(negedge clk);
    #1;
    chk("ar_post_stall", stall, 0);

    // random run
    do_reset();
    cyc = 0; in_rest = 0; rest_start = 0;
    trap_at = -10; redir_at = -10;
    m_err = 0; m_cnt = 0; m_kpc = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    for (int r = 0; r < 3000; r++) begin
      bit trap, redir, idle;
      @(negedge clk);
      kill = ($urandom % 8) == 0;
      kpc = $urandom;
      rec_we = in_rest ? (($urandom % 8) != 0)
                       : (($urandom % 300) == 0);
      rec_dest = 5'($urandom);
      rec_val = $urandom;
      exc = in_rest ? (($urandom % 40) == 0)
                    : (($urandom % 300) == 0);
      wb_we = 1'($urandom);
      wb_dest = 5'($urandom);
      wb_val = $urandom;
      e_mepc = $urandom; e_mcause = $urandom;
      e_mtval = $urandom; mtvec = $urandom;
      #1;
      trap = (cyc == trap_at);
      redir = (cyc == redir_at);
      idle = !in_rest && !trap && !redir;
      if (idle) begin
        chk("r_we", rf_we, wb_we && wb_dest != 0);
        chk("r_addr", rf_addr, wb_dest);
        chk("r_data", rf_data, wb_val);
      end else if (in_rest) begin
        chk("r_we", rf_we, rec_we && rec_dest != 0);
        chk("r_addr", rf_addr, rec_dest);
        chk("r_data", rf_data, rec_val);
      end else begin
        chk("r_we", rf_we, 0);
      end
      chk("r_drop", drop, wb_we && !idle);
      chk("r_stall", stall, !idle);
      chk("r_flush", flush, in_rest || trap);
      chk("r_csr", csr_we, trap);
      chk("r_pcv", pcv, redir);
      if (redir) chk("r_pc", pc, {mtvec[31:2], 2'b00});
      if (trap) begin
        chk("r_mepc", mepc, m_mepc);
        chk("r_mcause", mcause, m_mcause);
        chk("r_mtval", mtval, m_mtval);
      end
      chk("r_cnt", cnt, m_cnt);
      chk("r_err", err, m_err);
      if (in_rest) begin
        if (rec_we && m_cnt != 31) m_cnt = m_cnt + 1;
        if (exc) begin
          m_mepc = e_mepc; m_mcause = e_mcause;
          m_mtval = e_mtval;
          in_rest = 0; trap_at = cyc + 1; redir_at = cyc + 2;
        end else if (cyc - rest_start + 1 == MAXR) begin
          m_err = 1;
          m_mepc = m_kpc; m_mcause = 32'h18; m_mtval = 0;
          in_rest = 0; trap_at = cyc + 1; redir_at = cyc + 2;
        end
      end else if (idle) begin
        if (exc || rec_we) m_err = 1;
        if (kill) begin
          in_rest = 1; rest_start = cyc + 1;
          m_cnt = 0; m_kpc = kpc;
        end
      end
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
